// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage.
//
// Owns the program counter, drives it as the byte address into the
// instruction memory, and captures the returned word together with PC+4
// into the IF/ID pipeline register.
//
// Priority on each rising edge:
//   halted > branch > jump > stall > normal fetch.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   Read_address    byte address to instruction memory (= PC)
//   Instruction     word returned by memory for Read_address (same cycle)
//   stall           hazard-unit hold request
//   branch_taken    resolved taken branch, target on branch_target
//   jump            jump request, target on jump_target
//   if_id_instr     registered instruction for decode
//   if_id_pc4       registered PC+4 of that instruction
//   if_id_valid     if_id_instr is a real fetched instruction
//   addr_err        sticky fetch-address fault (halts fetch until reset)
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 160,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] Read_address,
  input  logic [31:0] Instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        addr_err
);

  // Highest legal word address.
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  logic [31:0] pc_q,    pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q,   pc4_d;
  logic        valid_q, valid_d;
  logic        err_q,   err_d;

  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] target;
  logic        target_ok;

  assign pc_plus4  = pc_q + 32'd4;
  assign redirect  = branch_taken | jump;
  // Branch is the older instruction, so its target wins over a jump.
  assign target    = branch_taken ? branch_target : jump_target;
  assign target_ok = (target[1:0] == 2'b00) && (target <= LAST_WORD);

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    err_d   = err_q;

    if (err_q) begin
      // Halted: PC frozen, bubbles only.
      instr_d = NOP_WORD;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (redirect) begin
      // Redirect overrides stall and always flushes the wrong-path word.
      instr_d = NOP_WORD;
      pc4_d   = '0;
      valid_d = 1'b0;
      if (target_ok) begin
        pc_d = target;
      end else begin
        err_d = 1'b1;
      end
    end else if (!stall) begin
      instr_d = Instruction;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      // The last word is still delivered; only the advance past it faults.
      if (pc_plus4 <= LAST_WORD) begin
        pc_d = pc_plus4;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign Read_address = pc_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_valid  = valid_q;
  assign addr_err     = err_q;

endmodule
